// File: rtl/if_pkg.sv
// Shared constants, state type and helpers for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [31:0] PC_INC      = 32'd4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // True for the two environment-call instructions that stop fetch.
    function automatic logic is_halt_inst(input logic [31:0] inst);
        return (inst == ECALL_INST) || (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: rst > bubble > load > hold.
// A bubble is a NOP with valid low and zero PCs.
module if_id_reg
    import if_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                bubble,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    input  logic [31:0]         fetch_inst,
    output logic [PC_WIDTH-1:0] ifid_pc,
    output logic [PC_WIDTH-1:0] ifid_pc4,
    output logic [31:0]         ifid_inst,
    output logic                ifid_valid
);

    // Pipeline register update: reset, squash, capture or hold.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ifid_pc    <= {PC_WIDTH{1'b0}};
            ifid_pc4   <= {PC_WIDTH{1'b0}};
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_pc    <= fetch_pc;
            ifid_pc4   <= fetch_pc + PC_WIDTH'(PC_INC);
            ifid_inst  <= fetch_inst;
            ifid_valid <= 1'b1;
        end else begin
            ifid_pc    <= ifid_pc;
            ifid_pc4   <= ifid_pc4;
            ifid_inst  <= ifid_inst;
            ifid_valid <= ifid_valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem word addressing, IF/ID capture,
// stall / redirect handling and halt on ECALL/EBREAK.
// Optional performance counters are built when IF_PERF_CNT_EN is defined;
// otherwise fetch_cnt_o / stall_cnt_o read constant zero.
module fetch_stage
    import if_pkg::*;
#(
    parameter int                PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                IMEM_ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic [IMEM_ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]            imem_data_i,
    output logic [PC_WIDTH-1:0]    ifid_pc_o,
    output logic [PC_WIDTH-1:0]    ifid_pc4_o,
    output logic [31:0]            ifid_inst_o,
    output logic                   ifid_valid_o,
    output logic                   halted_o,
    output logic [31:0]            fetch_cnt_o,
    output logic [31:0]            stall_cnt_o
);

    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_next_s;
    fetch_state_t        state_r;
    fetch_state_t        state_next_s;
    logic                halted_r;
    logic                ifid_load_s;
    logic                ifid_bubble_s;

    // Memory wraps at 64 words; upper PC bits are kept but not used here.
    assign imem_addr_o = pc_r[IMEM_ADDR_W+1:2];
    assign halted_o    = halted_r;

    // Next PC, next state and IF/ID control; redirect outranks stall.
    always_comb begin
        pc_next_s     = pc_r;
        state_next_s  = state_r;
        ifid_load_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        if (redirect_i) begin
            // Targets are word aligned: the low two bits are dropped.
            pc_next_s     = redirect_pc_i & ~PC_WIDTH'(3);
            ifid_bubble_s = 1'b1;
            state_next_s  = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (stall_i) begin
                        pc_next_s = pc_r;
                    end else begin
                        ifid_load_s = 1'b1;
                        if (is_halt_inst(imem_data_i)) begin
                            state_next_s = HALT;
                        end else begin
                            pc_next_s = pc_r + PC_WIDTH'(PC_INC);
                        end
                    end
                end
                HALT: begin
                    if (stall_i) begin
                        ifid_bubble_s = 1'b0;
                    end else begin
                        ifid_bubble_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s = RUN;
                end
            endcase
        end
    end

    // PC, state and the registered halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            state_r  <= RUN;
            halted_r <= 1'b0;
        end else begin
            pc_r     <= pc_next_s;
            state_r  <= state_next_s;
            halted_r <= (state_r == HALT) && !redirect_i;
        end
    end

    if_id_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load_s),
        .bubble     (ifid_bubble_s),
        .fetch_pc   (pc_r),
        .fetch_inst (imem_data_i),
        .ifid_pc    (ifid_pc_o),
        .ifid_pc4   (ifid_pc4_o),
        .ifid_inst  (ifid_inst_o),
        .ifid_valid (ifid_valid_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;
    logic        stall_inc_s;

    assign stall_inc_s = (state_r == RUN) && stall_i && !redirect_i;
    assign fetch_cnt_o = fetch_cnt_r;
    assign stall_cnt_o = stall_cnt_r;

    // Count valid IF/ID loads and RUN-state stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            fetch_cnt_r <= fetch_cnt_r + (ifid_load_s ? 32'd1 : 32'd0);
            stall_cnt_r <= stall_cnt_r + (stall_inc_s ? 32'd1 : 32'd0);
        end
    end
`else
    assign fetch_cnt_o = 32'd0;
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with hand-computed expected values.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] I_LW0  = 32'h0000_2083;
    localparam logic [31:0] I_LW1  = 32'h0040_2103;
    localparam logic [31:0] I_ADD  = 32'h0020_81b3;
    localparam logic [31:0] I_SUB  = 32'h4020_8233;

`ifdef IF_PERF_CNT_EN
    localparam logic [31:0] EXP_F3 = 32'd3;
    localparam logic [31:0] EXP_S2 = 32'd2;
    localparam logic [31:0] EXP_F5 = 32'd5;
    localparam logic [31:0] EXP_S3 = 32'd3;
`else
    localparam logic [31:0] EXP_F3 = 32'd0;
    localparam logic [31:0] EXP_S2 = 32'd0;
    localparam logic [31:0] EXP_F5 = 32'd0;
    localparam logic [31:0] EXP_S3 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    logic [31:0] mem [64];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_inst_o   (ifid_inst),
        .ifid_valid_o  (ifid_valid),
        .halted_o      (halted),
        .fetch_cnt_o   (fetch_cnt),
        .stall_cnt_o   (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst, input logic valid);
        check({tag, "_pc"}, ifid_pc, pc);
        check({tag, "_pc4"}, ifid_pc4, (valid ? pc + 32'd4 : 32'd0));
        check({tag, "_inst"}, ifid_inst, inst);
        check({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = NOP;
        mem[0] = I_LW0;
        mem[1] = I_LW1;
        mem[2] = I_ADD;
        mem[3] = I_SUB;
        mem[4] = EBRK;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        check("rst_addr", {26'd0, imem_addr}, 32'd0);
        check_ifid("rst", 32'd0, NOP, 1'b0);
        check("rst_halt", {31'd0, halted}, 32'd0);
        check("rst_fcnt", fetch_cnt, 32'd0);
        check("rst_scnt", stall_cnt, 32'd0);
        rst = 1'b0;

        // Free run
        tick();
        check("run1_addr", {26'd0, imem_addr}, 32'd1);
        check_ifid("run1", 32'd0, I_LW0, 1'b1);
        tick();
        check("run2_addr", {26'd0, imem_addr}, 32'd2);
        check_ifid("run2", 32'd4, I_LW1, 1'b1);

        // Two stall cycles with pc = 8
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_addr", {26'd0, imem_addr}, 32'd2);
            check_ifid("stall", 32'd4, I_LW1, 1'b1);
        end
        stall = 1'b0;
        tick();
        check("resume_addr", {26'd0, imem_addr}, 32'd3);
        check_ifid("resume", 32'd8, I_ADD, 1'b1);
        check("cnt_f3", fetch_cnt, EXP_F3);
        check("cnt_s2", stall_cnt, EXP_S2);

        // Redirect with stall, unaligned target
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0023;
        tick();
        check("redir_addr", {26'd0, imem_addr}, 32'd8);
        check_ifid("redir", 32'd0, NOP, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        tick();
        check("after_redir_addr", {26'd0, imem_addr}, 32'd9);
        check_ifid("after_redir", 32'h20, NOP, 1'b1);

        // Redirect to EBREAK word
        redirect = 1'b1; redirect_pc = 32'h0000_0010;
        tick();
        check("to_ebrk_addr", {26'd0, imem_addr}, 32'd4);
        redirect = 1'b0;
        tick();
        check_ifid("ebrk", 32'd16, EBRK, 1'b1);
        check("ebrk_halt0", {31'd0, halted}, 32'd0);
        check("ebrk_addr", {26'd0, imem_addr}, 32'd4);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_addr", {26'd0, imem_addr}, 32'd4);
            check_ifid("halt_bub", 32'd0, NOP, 1'b0);
        end

        // Leave HALT by redirect to 0
        redirect = 1'b1; redirect_pc = 32'd0;
        tick();
        check("unhalt_flag", {31'd0, halted}, 32'd0);
        check("unhalt_addr", {26'd0, imem_addr}, 32'd0);
        redirect = 1'b0;
        tick();
        check("restart_addr", {26'd0, imem_addr}, 32'd1);
        check_ifid("restart", 32'd0, I_LW0, 1'b1);

        // Word-address wrap at 0xFC
        redirect = 1'b1; redirect_pc = 32'h0000_00FC;
        tick();
        check("wrap_addr63", {26'd0, imem_addr}, 32'd63);
        redirect = 1'b0;
        tick();
        check("wrap_addr0", {26'd0, imem_addr}, 32'd0);
        check_ifid("wrap", 32'h0000_00FC, NOP, 1'b1);
        check("wrap_pc4", ifid_pc4, 32'h0000_0100);
        tick();
        check_ifid("wrap_next", 32'h0000_0100, I_LW0, 1'b1);

        // Counter section: reset, move to NOP region, 5 fetches, 3 stalls, reset
        rst = 1'b1;
        tick();
        check("rst2_fcnt", fetch_cnt, 32'd0);
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0020;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("cnt_f5", fetch_cnt, EXP_F5);
        check("cnt_s0", stall_cnt, 32'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("cnt_s3", stall_cnt, EXP_S3);
        check("cnt_f5_hold", fetch_cnt, EXP_F5);
        rst = 1'b1;
        tick();
        check("cnt_clr_f", fetch_cnt, 32'd0);
        check("cnt_clr_s", stall_cnt, 32'd0);
        check_ifid("rst3", 32'd0, NOP, 1'b0);
        check("rst3_addr", {26'd0, imem_addr}, 32'd0);
        rst = 1'b0; stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined RV32I core, directly upstream of the instruction memory. It holds the PC and drives the instruction memory's 6-bit word address. It captures the returned 32-bit instruction into the IF/ID pipeline register. It also handles hazard stalls, branch/jump redirects, and halting on ECALL/EBREAK.

Parameters:
PC_WIDTH, 32, width of PC and all address ports
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_ADDR_W, 6, instruction memory word-address width (64 words)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall_i  in  1  hazard-unit stall; hold PC and IF/ID
redirect_i  in  1  taken branch/jump from EX; flush and reload PC
redirect_pc_i  in  PC_WIDTH  redirect target
imem_addr_o  out  IMEM_ADDR_W  word address to instruction memory
imem_data_i  in  32  instruction from instruction memory, combinational read
ifid_pc_o  out  PC_WIDTH  PC of instruction in IF/ID
ifid_pc4_o  out  PC_WIDTH  ifid_pc_o + 4
ifid_inst_o  out  32  instruction in IF/ID
ifid_valid_o  out  1  IF/ID holds a real instruction
halted_o  out  1  fetch halted
fetch_cnt_o  out  32  perf counter (see Optional Feature)
stall_cnt_o  out  32  perf counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. Reset wins over every other input.
- Reset values:
  - pc_q = RESET_PC.
  - ifid_pc_o = 0 and ifid_pc4_o = 0.
  - ifid_inst_o = NOP (32'h0000_0013).
  - ifid_valid_o = 0 and halted_o = 0.
  - state = RUN; counters = 0.
- Address: imem_addr_o = pc_q[IMEM_ADDR_W+1:2], combinational. It wraps modulo 64 words; PC bits above the address range are ignored by memory but kept in pc_q.
- Latency: an instruction fetched at PC in cycle N appears on ifid_* in cycle N+1.
- States are RUN and HALT. Per-cycle priority: rst > redirect_i > stall_i > normal.
- RUN, normal cycle:
  - IF/ID <= {pc_q, pc_q+4, imem_data_i, valid=1}.
  - pc_q <= pc_q+4, wrapping at 2^PC_WIDTH.
  - If imem_data_i is ECALL (32'h0000_0073) or EBREAK (32'h0010_0073): it is still latched valid, pc_q holds, and state becomes HALT.
- RUN, stall_i=1 and redirect_i=0: pc_q and the whole IF/ID register hold. No halt detection that cycle.
- redirect_i=1, in any state, including together with stall_i:
  - pc_q <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00}; the low 2 bits are forced to zero.
  - IF/ID <= bubble (inst NOP, valid 0, pc/pc4 0).
  - state <= RUN. The instruction at the target is fetched the next cycle.
- HALT:
  - halted_o = 1 (registered: asserted the cycle after the halting instruction enters IF/ID).
  - pc_q holds. If stall_i=0, IF/ID loads a bubble; if stall_i=1, IF/ID holds.
  - Only redirect_i or rst leave HALT. This covers an older taken branch squashing a speculative EBREAK.
- Reset mid-stall or mid-halt: reset values apply on the next edge, with no residual bubble or halt.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - fetch_cnt_o increments each edge on which IF/ID loads with valid=1.
  - stall_cnt_o increments each edge with state=RUN, stall_i=1, redirect_i=0.
  - Both wrap at 2^32 and clear on rst.
- Undefined: both ports remain and are tied to 32'h0. No counter flops.

Decomposition:
- Package if_pkg holds:
  - NOP_INST = 32'h0000_0013, ECALL_INST, EBREAK_INST.
  - fetch_state_t enum {RUN, HALT}.
  - PC increment constant 4.
- One natural sub-module: if_id_reg. It is the IF/ID register with load/hold/bubble control, instantiated once.

Test Plan:
- Reset then free-run with memory words 0..3 = lw/lw/add/sub -> imem_addr_o 0,1,2,3 on successive cycles; ifid_pc_o 0,4,8,12 one cycle later; valid=1 from the second cycle after reset.
- stall_i high 2 cycles while pc_q=8 -> imem_addr_o stays 2, ifid_pc_o stays 4 with unchanged inst; the sequence resumes at 8 afterwards.
- redirect_i with redirect_pc_i=32'h0000_0023 and stall_i=1 at the same time -> next cycle pc_q=0x20, imem_addr_o=8, ifid_valid_o=0, ifid_inst_o=0x00000013.
- Word 4 = 32'h0010_0073 -> EBREAK latched valid at ifid_pc_o=16; halted_o=1 the following cycle; imem_addr_o frozen at 4; bubbles follow. Then redirect to 0 -> halted_o=0, fetch restarts at address 0.
- PC at 0xFC (word 63) -> next imem_addr_o=0 while pc_q=0x100; ifid_pc4_o=0x100.
- With IF_PERF_CNT_EN: 5 fetches, then 3 stall cycles, then rst -> fetch_cnt_o=5, stall_cnt_o=3, then both 0; without the macro both always read 0.
